// File: rtl/opbomp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | opbomp_pkg : shared types and default dimensions for the OPBOMP sched  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package opbomp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int c_n              = 24;
    localparam int c_data_width     = 16;
    localparam int c_size_blocks    = 3;
    localparam int c_num_blocks     = 32;
    localparam int c_log_num_blocks = $clog2(c_num_blocks);
    localparam int c_metric_width   = 40;
    localparam int c_timeout        = 64;

    // Decision word layout: block index in the MSBs, sign bits in the LSBs.
    localparam int c_sign_lsb  = 0;
    localparam int c_idx_lsb   = c_size_blocks;
    localparam int c_out_width = c_log_num_blocks + c_size_blocks;

endpackage
`default_nettype wire

// File: rtl/opbomp_sched_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | opbomp_sched_if : frame input, correlator and decision-output bundle  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface opbomp_sched_if import opbomp_pkg::*; #(
    parameter int N              = c_n,
    parameter int DATA_WIDTH     = c_data_width,
    parameter int SIZE_BLOCKS    = c_size_blocks,
    parameter int NUM_BLOCKS     = c_num_blocks,
    parameter int LOG_NUM_BLOCKS = $clog2(NUM_BLOCKS),
    parameter int METRIC_WIDTH   = c_metric_width
) ();

    logic                                  in_valid;
    logic                                  in_ready;
    logic [N*DATA_WIDTH-1:0]               x_in;
    logic                                  corr_req_valid;
    logic [LOG_NUM_BLOCKS-1:0]             corr_block_idx;
    logic [N*DATA_WIDTH-1:0]               corr_x;
    logic                                  corr_rsp_valid;
    logic [METRIC_WIDTH-1:0]               corr_metric;
    logic [SIZE_BLOCKS-1:0]                corr_signs;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [LOG_NUM_BLOCKS+SIZE_BLOCKS-1:0] output_bits;
    logic                                  err_timeout;

    // master = the scheduler, slave = source/correlator/sink environment
    modport master (
        input  in_valid, x_in, corr_rsp_valid, corr_metric, corr_signs, out_ready,
        output in_ready, corr_req_valid, corr_block_idx, corr_x, out_valid,
               output_bits, err_timeout
    );

    modport slave (
        output in_valid, x_in, corr_rsp_valid, corr_metric, corr_signs, out_ready,
        input  in_ready, corr_req_valid, corr_block_idx, corr_x, out_valid,
               output_bits, err_timeout
    );

endinterface
`default_nettype wire

// File: rtl/opbomp_argmax.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | opbomp_argmax : running best-metric / index / sign-word tracker       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module opbomp_argmax import opbomp_pkg::*; #(
    parameter int SIZE_BLOCKS    = c_size_blocks,
    parameter int LOG_NUM_BLOCKS = c_log_num_blocks,
    parameter int METRIC_WIDTH   = c_metric_width
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear,
    input  logic                                  update,
    input  logic                                  first,
    input  logic [LOG_NUM_BLOCKS-1:0]             idx,
    input  logic [METRIC_WIDTH-1:0]               metric,
    input  logic [SIZE_BLOCKS-1:0]                signs,
    output logic [LOG_NUM_BLOCKS+SIZE_BLOCKS-1:0] best_word
);

    logic [METRIC_WIDTH-1:0]   r_best_metric;
    logic [LOG_NUM_BLOCKS-1:0] r_best_idx;
    logic [SIZE_BLOCKS-1:0]    r_best_signs;
    logic                      w_take;

    // Strict compare so that ties keep the earlier (lower) block index.
    assign w_take = update && (first || (metric > r_best_metric));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_metric <= '0;
            r_best_idx    <= '0;
            r_best_signs  <= '0;
        end else if (clear) begin
            r_best_metric <= '0;
            r_best_idx    <= '0;
            r_best_signs  <= '0;
        end else if (w_take) begin
            r_best_metric <= metric;
            r_best_idx    <= idx;
            r_best_signs  <= signs;
        end
    end

    assign best_word = {r_best_idx, r_best_signs};

endmodule
`default_nettype wire

// File: rtl/opbomp_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | opbomp_sched : frame scheduler time-sharing one block correlator      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module opbomp_sched import opbomp_pkg::*; #(
    parameter int N              = c_n,
    parameter int DATA_WIDTH     = c_data_width,
    parameter int SIZE_BLOCKS    = c_size_blocks,
    parameter int NUM_BLOCKS     = c_num_blocks,
    parameter int LOG_NUM_BLOCKS = $clog2(NUM_BLOCKS),
    parameter int METRIC_WIDTH   = c_metric_width,
    parameter int TIMEOUT        = c_timeout
) (
    input  logic              clk,
    input  logic              rst_n,
    opbomp_sched_if.master    bus
);

    localparam int c_timer_w = $clog2(TIMEOUT);
    localparam logic [c_timer_w-1:0]      c_timer_last = c_timer_w'(TIMEOUT - 1);
    localparam logic [LOG_NUM_BLOCKS-1:0] c_idx_last   = LOG_NUM_BLOCKS'(NUM_BLOCKS - 1);

    state_t                                r_state;
    logic [LOG_NUM_BLOCKS-1:0]             r_idx;
    logic [c_timer_w-1:0]                  r_timer;
    logic [N*DATA_WIDTH-1:0]               r_x;
    logic                                  r_in_ready;
    logic                                  r_req;
    logic                                  r_out_valid;
    logic                                  r_err;

    logic                                  w_accept;
    logic                                  w_rsp;
    logic                                  w_expire;
    logic                                  w_advance;
    logic                                  w_last;
    logic [c_timer_w-1:0]                  w_timer_nxt;
    logic [LOG_NUM_BLOCKS+SIZE_BLOCKS-1:0] w_best_word;

    assign w_accept    = (r_state == ST_IDLE) && r_in_ready && bus.in_valid;
    assign w_rsp       = (r_state == ST_WAIT) && bus.corr_rsp_valid;
    assign w_timer_nxt = r_timer + c_timer_w'(1);
    // The request cycle plus WAIT cycles add up to TIMEOUT before giving up.
    assign w_expire    = (r_state == ST_WAIT) && !bus.corr_rsp_valid &&
                         (w_timer_nxt == c_timer_last);
    assign w_advance   = w_rsp || w_expire;
    assign w_last      = (r_idx == c_idx_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_timer     <= '0;
            r_x         <= '0;
            r_in_ready  <= 1'b0;
            r_req       <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_x        <= bus.x_in;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_req      <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_req   <= 1'b0;
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_advance) begin
                        if (w_expire) begin
                            r_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + LOG_NUM_BLOCKS'(1);
                            r_req   <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end else begin
                        r_timer <= w_timer_nxt;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    opbomp_argmax #(
        .SIZE_BLOCKS    (SIZE_BLOCKS),
        .LOG_NUM_BLOCKS (LOG_NUM_BLOCKS),
        .METRIC_WIDTH   (METRIC_WIDTH)
    ) u_argmax (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_accept),
        .update    (w_rsp),
        .first     (r_idx == '0),
        .idx       (r_idx),
        .metric    (bus.corr_metric),
        .signs     (bus.corr_signs),
        .best_word (w_best_word)
    );

    assign bus.in_ready       = r_in_ready;
    assign bus.corr_req_valid = r_req;
    assign bus.corr_block_idx = r_idx;
    assign bus.corr_x         = r_x;
    assign bus.out_valid      = r_out_valid;
    assign bus.output_bits    = r_out_valid ? w_best_word : '0;
    assign bus.err_timeout    = r_err;

endmodule
`default_nettype wire

// File: doc/opbomp_sched.md
Name: opbomp_sched

Overview:
- Frame-level scheduler for the OPBOMP detector.
- Accepts one received vector x (N samples) per frame via valid/ready and latches it.
- Time-multiplexes a single shared block correlator over all NUM_BLOCKS candidate blocks, tracking the best metric.
- Emits the 8-bit decision word {block index, sign bits} to the downstream symbol sink via valid/ready.

Parameters:
- SIZE_BLOCKS, 3, samples per block; also the number of sign bits in the output word.
- N, 24, samples per frame.
- DATA_WIDTH, 16, two's-complement sample width.
- NUM_BLOCKS, 32, candidate blocks scanned per frame.
- LOG_NUM_BLOCKS, $clog2(NUM_BLOCKS), width of the block index.
- METRIC_WIDTH, 40, unsigned correlator metric width.
- TIMEOUT, 64, maximum cycles to wait for one correlator response.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  x_in holds a valid frame.
- in_ready  out  1  scheduler can accept a frame.
- x_in  in  N*DATA_WIDTH  frame; sample 0 in the MSBs.
- corr_req_valid  out  1  correlation request (single-cycle pulse).
- corr_block_idx  out  LOG_NUM_BLOCKS  block being evaluated.
- corr_x  out  N*DATA_WIDTH  latched frame, stable from accept until the frame completes.
- corr_rsp_valid  in  1  correlator result valid (single-cycle pulse).
- corr_metric  in  METRIC_WIDTH  unsigned metric for the requested block.
- corr_signs  in  SIZE_BLOCKS  per-sample sign decisions; 1 = positive.
- out_valid  out  1  output_bits is valid.
- out_ready  in  1  sink accepts the output.
- output_bits  out  LOG_NUM_BLOCKS+SIZE_BLOCKS  {best_idx, best_signs}.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset values: all outputs 0 except in_ready, which is 0 during reset and 1 in the first cycle after reset deassertion. Internal idx, best_metric, best_idx, best_signs and timer are all 0. Asserting reset mid-operation aborts the frame immediately; any late corr_rsp_valid after reset is ignored in IDLE.
- States:
  - IDLE: in_ready=1. On in_valid, latch x_in to corr_x, set idx=0, clear best registers -> ISSUE.
  - ISSUE: corr_req_valid=1 for exactly one cycle with corr_block_idx=idx; clear timer -> WAIT.
  - WAIT: timer increments each cycle.
    - On corr_rsp_valid: update best if (idx==0) or (corr_metric > best_metric); best_idx=idx, best_signs=corr_signs. Then if idx==NUM_BLOCKS-1 -> DONE, else idx+1 -> ISSUE.
    - Ties keep the lower index (strict >).
    - If timer reaches TIMEOUT-1 without a response: set err_timeout, treat the block metric as 0 (no update), advance as above.
  - DONE: out_valid=1, output_bits={best_idx,best_signs}, held stable until out_ready. On out_valid&&out_ready -> IDLE.
- in_ready is 1 only in IDLE; there is no frame overlap.
- corr_rsp_valid outside WAIT is ignored.
- Minimum frame latency with a correlator latency of L cycles: 1 + NUM_BLOCKS*(L+1) cycles from accept to out_valid. For L=1 and NUM_BLOCKS=32: 65 cycles.
- err_timeout is sticky; it is cleared only by rst_n.
- Metric comparison is unsigned at full METRIC_WIDTH, with no truncation.

Decomposition:
- Shared package opbomp_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, DONE);
  - the default N, DATA_WIDTH, SIZE_BLOCKS, NUM_BLOCKS;
  - the output-word field positions (index MSBs, signs LSBs).
- One natural sub-module: opbomp_argmax, the best-metric/index/sign tracker with clear and update inputs. The FSM and timeout counter stay in opbomp_sched.

Test Plan:
- Frame with the correlator model returning metric=100 for all blocks except block 26=900 (signs 3'b001), L=1 -> output_bits=8'b11010001 at cycle 65 after accept; in_ready=0 throughout the frame.
- Equal metric 500 on blocks 4 and 17, all others 10 -> best_idx=4 (lowest index wins).
- Hold out_ready=0 for 20 cycles after out_valid -> output_bits stable, in_ready=0; then out_ready=1 for 1 cycle -> back to IDLE, in_ready=1 next cycle.
- Correlator never responds for block 7, TIMEOUT=64 -> err_timeout=1 at 64 cycles after that request; the scan continues and block 7 is never selected; the flag stays 1 over the next frame.
- Assert rst_n=0 mid-scan at idx=12 -> all outputs 0 immediately. A stray corr_rsp_valid after reset release causes no state change. A new frame completes normally.
- Two back-to-back frames with in_valid held high -> the second is accepted only after the first output handshake; each gets its correct best_idx (e.g. 3, then 30).
